// File: rtl/spsram_banked_if.sv
// Request/response bundle for the banked single-port SRAM.
// master drives requests; slave is the memory side.
interface spsram_banked_if #(
  parameter int BW_DATA = 64,
  parameter int BW_ADDR = 6
);
  logic                 i_req;
  logic                 i_wen;
  logic [BW_ADDR-1:0]   i_addr;
  logic [BW_DATA-1:0]   i_data;
  logic [BW_DATA/8-1:0] i_be;
  logic [BW_DATA-1:0]   o_data;
  logic                 o_valid;
  logic                 o_ready;

  modport master (
    output i_req, i_wen, i_addr, i_data, i_be,
    input  o_data, o_valid, o_ready
  );

  modport slave (
    input  i_req, i_wen, i_addr, i_data, i_be,
    output o_data, o_valid, o_ready
  );
endinterface

// File: rtl/spsram_banked.sv
// Banked single-port SRAM: rows of macros picked by upper address bits,
// columns concatenated for width, byte masks, zero-clear after reset.
module spsram_banked #(
  parameter int BW_DATA      = 64,
  parameter int BW_ADDR      = 6,
  parameter int BW_BANK_ADDR = 4,
  parameter int BW_SUB       = 32,
  parameter int RD_LAT       = 1
) (
  input logic             i_clk,
  input logic             i_rst,
  spsram_banked_if.slave  bus
);
  localparam int BW_ROW  = BW_ADDR - BW_BANK_ADDR;
  localparam int NUM_ROW = 2**BW_ROW;
  localparam int NUM_COL = BW_DATA / BW_SUB;
  localparam int DEPTH   = 2**BW_BANK_ADDR;
  localparam int NB_SUB  = BW_SUB / 8;

  localparam logic [0:0] ST_CLEAR = 1'b0;
  localparam logic [0:0] ST_READY = 1'b1;

  logic [0:0]              state_q;
  logic [BW_BANK_ADDR-1:0] clr_cnt_q;
  logic                    ready;
  logic                    wr_acc;
  logic                    rd_acc;
  logic [BW_ROW-1:0]       row;
  logic [NUM_ROW-1:0]      row_oh;
  logic [NUM_ROW-1:0]      we_row;
  logic [NUM_ROW-1:0]      re_row;
  logic [BW_BANK_ADDR-1:0] m_addr;
  logic [BW_DATA-1:0]      wdata;
  logic [BW_DATA/8-1:0]    wbe;

  assign ready  = (state_q == ST_READY);
  assign wr_acc = bus.i_req & ready & bus.i_wen;
  assign rd_acc = bus.i_req & ready & ~bus.i_wen;
  assign row    = bus.i_addr[BW_ADDR-1:BW_BANK_ADDR];

  always_comb begin
    row_oh      = '0;
    row_oh[row] = 1'b1;
  end

  // Clearing hijacks the port: every macro writes zero at the counter.
  assign m_addr = ready ? bus.i_addr[BW_BANK_ADDR-1:0] : clr_cnt_q;
  assign wdata  = ready ? bus.i_data : '0;
  assign wbe    = ready ? bus.i_be : '1;
  assign we_row = ready ? (wr_acc ? row_oh : '0) : '1;
  assign re_row = rd_acc ? row_oh : '0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= ST_CLEAR;
      clr_cnt_q <= '0;
    end else if (state_q == ST_CLEAR) begin
      clr_cnt_q <= clr_cnt_q + 1'b1;
      if (clr_cnt_q == BW_BANK_ADDR'(DEPTH - 1))
        state_q <= ST_READY;
    end
  end

  logic [NUM_ROW-1:0][BW_DATA-1:0] rdout;

  for (genvar r = 0; r < NUM_ROW; r++) begin : g_row
    for (genvar c = 0; c < NUM_COL; c++) begin : g_col
      logic [BW_SUB-1:0] mem [DEPTH];
      logic [BW_SUB-1:0] dout_q;

      always_ff @(posedge i_clk) begin
        if (we_row[r]) begin
          for (int b = 0; b < NB_SUB; b++) begin
            if (wbe[c*NB_SUB+b])
              mem[m_addr][8*b +: 8] <= wdata[c*BW_SUB+8*b +: 8];
          end
        end
        if (re_row[r])
          dout_q <= mem[m_addr];
      end

      assign rdout[r][c*BW_SUB +: BW_SUB] = dout_q;
    end
  end

  logic               rv_q;
  logic [NUM_ROW-1:0] rsel_q;
  logic [BW_DATA-1:0] rmux;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      rv_q   <= 1'b0;
      rsel_q <= '0;
    end else begin
      rv_q <= rd_acc;
      if (rd_acc)
        rsel_q <= row_oh;
    end
  end

  always_comb begin
    rmux = '0;
    for (int r = 0; r < NUM_ROW; r++) begin
      if (rsel_q[r])
        rmux = rmux | rdout[r];
    end
  end

  logic               vld_q;
  logic [BW_DATA-1:0] dat_q;

  if (RD_LAT == 1) begin : g_lat1
    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        vld_q <= 1'b0;
        dat_q <= '0;
      end else begin
        vld_q <= rv_q;
        if (rv_q)
          dat_q <= rmux;
      end
    end
  end else if (RD_LAT == 2) begin : g_lat2
    logic               v2_q;
    logic [BW_DATA-1:0] d2_q;

    always_ff @(posedge i_clk) begin
      if (i_rst) begin
        v2_q  <= 1'b0;
        d2_q  <= '0;
        vld_q <= 1'b0;
        dat_q <= '0;
      end else begin
        v2_q  <= rv_q;
        vld_q <= v2_q;
        if (rv_q)
          d2_q <= rmux;
        if (v2_q)
          dat_q <= d2_q;
      end
    end
  end else begin : g_bad_lat
    $error("spsram_banked: RD_LAT must be 1 or 2");
  end

  assign bus.o_ready = ready;
  assign bus.o_valid = vld_q;
  assign bus.o_data  = dat_q;
endmodule

// File: tb/tb_spsram_banked.sv
// Directed bench for spsram_banked: one RD_LAT=1 and one RD_LAT=2
// instance share clock, reset and stimulus.
module tb_spsram_banked;
  logic        clk;
  logic        rst;
  logic        req;
  logic        wen;
  logic [5:0]  addr;
  logic [63:0] data;
  logic [7:0]  be;
  int          n_vec;
  int          n_bad;

  spsram_banked_if #(.BW_DATA(64), .BW_ADDR(6)) bus1 ();
  spsram_banked_if #(.BW_DATA(64), .BW_ADDR(6)) bus2 ();

  assign bus1.i_req  = req;
  assign bus1.i_wen  = wen;
  assign bus1.i_addr = addr;
  assign bus1.i_data = data;
  assign bus1.i_be   = be;
  assign bus2.i_req  = req;
  assign bus2.i_wen  = wen;
  assign bus2.i_addr = addr;
  assign bus2.i_data = data;
  assign bus2.i_be   = be;

  spsram_banked #(.RD_LAT(1)) u_dut1 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus1.slave)
  );

  spsram_banked #(.RD_LAT(2)) u_dut2 (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus2.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] pat(input logic [5:0] a);
    logic [7:0] a8;
    a8 = {2'b00, a};
    return {a8, ~a8, a8 ^ 8'h5A, a8 + 8'h11,
            8'hA5, a8 ^ 8'hC3, 8'h3C, a8};
  endfunction

  task automatic wr(input logic [5:0] a, input logic [63:0] d,
                    input logic [7:0] m);
    req  = 1'b1;
    wen  = 1'b1;
    addr = a;
    data = d;
    be   = m;
    cyc();
    req  = 1'b0;
    chk("wr_novalid", {63'd0, bus1.o_valid}, 64'd0);
  endtask

  task automatic rd_chk(input string tag, input logic [5:0] a,
                        input logic [63:0] exp);
    req  = 1'b1;
    wen  = 1'b0;
    addr = a;
    be   = 8'h00;
    cyc();
    req  = 1'b0;
    chk({tag, "_v1_early"}, {63'd0, bus1.o_valid}, 64'd0);
    cyc();
    chk({tag, "_v1"}, {63'd0, bus1.o_valid}, 64'd1);
    chk({tag, "_d1"}, bus1.o_data, exp);
    chk({tag, "_v2_early"}, {63'd0, bus2.o_valid}, 64'd0);
    cyc();
    chk({tag, "_v2"}, {63'd0, bus2.o_valid}, 64'd1);
    chk({tag, "_d2"}, bus2.o_data, exp);
    chk({tag, "_v1_off"}, {63'd0, bus1.o_valid}, 64'd0);
    chk({tag, "_d1_hold"}, bus1.o_data, exp);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  initial begin
    n_vec = 0;
    n_bad = 0;
    rst   = 1'b1;
    req   = 1'b0;
    wen   = 1'b0;
    addr  = '0;
    data  = '0;
    be    = '0;

    // T1: reset state and clear length
    repeat (3) cyc();
    chk("rst_ready", {63'd0, bus1.o_ready}, 64'd0);
    chk("rst_valid", {63'd0, bus1.o_valid}, 64'd0);
    chk("rst_data", bus1.o_data, 64'd0);
    rst = 1'b0;
    for (int i = 1; i <= 16; i++) begin
      // T2: requests during clear must be dropped
      if (i == 10) begin
        req  = 1'b1;
        wen  = 1'b1;
        addr = 6'h05;
        data = 64'hDEAD_BEEF_0000_0001;
        be   = 8'hFF;
      end else if (i == 12) begin
        req  = 1'b1;
        wen  = 1'b0;
        addr = 6'h05;
      end else begin
        req = 1'b0;
      end
      cyc();
      chk("clr_ready", {63'd0, bus1.o_ready}, (i == 16) ? 64'd1 : 64'd0);
      chk("clr_valid", {63'd0, bus1.o_valid}, 64'd0);
    end
    req = 1'b0;
    rd_chk("t1_rd2a", 6'h2A, 64'd0);
    rd_chk("t2_rd05", 6'h05, 64'd0);

    // T3: fill and stream back
    for (int i = 0; i < 64; i++) wr(6'(i), pat(6'(i)), 8'hFF);
    for (int i = 0; i <= 65; i++) begin
      if (i < 64) begin
        req  = 1'b1;
        wen  = 1'b0;
        addr = 6'(i);
      end else begin
        req = 1'b0;
      end
      cyc();
      if (i >= 1 && i <= 64) begin
        chk("t3_v1", {63'd0, bus1.o_valid}, 64'd1);
        chk("t3_d1", bus1.o_data, pat(6'(i - 1)));
      end
      if (i >= 2) begin
        chk("t3_v2", {63'd0, bus2.o_valid}, 64'd1);
        chk("t3_d2", bus2.o_data, pat(6'(i - 2)));
      end
    end
    cyc();
    chk("t3_v1_end", {63'd0, bus1.o_valid}, 64'd0);
    chk("t3_v2_end", {63'd0, bus2.o_valid}, 64'd0);

    // T4: byte masks
    wr(6'h11, 64'h1122_3344_5566_7788, 8'hFF);
    wr(6'h11, 64'hFFFF_FFFF_FFFF_FFFF, 8'b1010_0101);
    wr(6'h11, 64'h0, 8'h00);
    rd_chk("t4_mask", 6'h11, 64'hFF22_FF44_55FF_77FF);
    rd_chk("t4_nbr", 6'h10, pat(6'h10));
    rd_chk("t4_row", 6'h21, pat(6'h21));

    // T5: write then read on the very next edge
    wr(6'h3F, 64'h0123_4567_89AB_CDEF, 8'hFF);
    rd_chk("t5_raw", 6'h3F, 64'h0123_4567_89AB_CDEF);

    // T6: reset with reads in flight
    req  = 1'b1;
    wen  = 1'b0;
    addr = 6'h11;
    cyc();
    addr = 6'h3F;
    cyc();
    req = 1'b0;
    rst = 1'b1;
    chk("t6_v1_pre", {63'd0, bus1.o_valid}, 64'd1);
    chk("t6_d1_pre", bus1.o_data, 64'hFF22_FF44_55FF_77FF);
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk("t6_v1", {63'd0, bus1.o_valid}, 64'd0);
      chk("t6_v2", {63'd0, bus2.o_valid}, 64'd0);
      chk("t6_ready", {63'd0, bus1.o_ready}, 64'd0);
      chk("t6_d1", bus1.o_data, 64'd0);
    end
    rst = 1'b0;
    for (int k = 0; k < 40 && !bus1.o_ready; k++) begin
      cyc();
      chk("t6_clr_v", {63'd0, bus1.o_valid | bus2.o_valid}, 64'd0);
    end
    chk("t6_ready_up", {63'd0, bus1.o_ready}, 64'd1);
    rd_chk("t6_rd11", 6'h11, 64'd0);
    rd_chk("t6_rd3f", 6'h3F, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
